// File: rtl/pipelined_logic_unit.sv
// rtl/pipelined_logic_unit.sv - two-stage ready/valid bitwise logic unit; optional zero flag via LU_ZERO_FLAG_EN
module pipelined_logic_unit #(
   parameter int WIDTH = 8,
   parameter int OP_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_valid,
   input  logic             out_ready
`ifdef LU_ZERO_FLAG_EN
   ,
   output logic             out_zero
`endif
);

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NAND = 3'b010,
      OP_NOR  = 3'b011,
      OP_XOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_NOTA = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] result;
   logic             s2_adv;
   logic             s1_adv;

   // S2 can take new data when it is empty or being drained this cycle.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_adv;
   assign in_ready = !s1_valid_q || s1_adv;

   always_comb begin
      result = a_q;
      case (op_e'(op_q))
         OP_AND:  result = a_q & b_q;
         OP_OR:   result = a_q | b_q;
         OP_NAND: result = ~(a_q & b_q);
         OP_NOR:  result = ~(a_q | b_q);
         OP_XOR:  result = a_q ^ b_q;
         OP_XNOR: result = ~(a_q ^ b_q);
         OP_NOTA: result = ~a_q;
         OP_PASS: result = a_q;
         default: result = a_q;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a_d  = in_a;
            b_d  = in_b;
            op_d = in_op;
         end
      end
   end

   // s_q keeps its last value when S2 drains with nothing behind it.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s_d        = s_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s_d = result;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         s2_valid_q <= 1'b0;
         s_q        <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         s2_valid_q <= s2_valid_d;
         s_q        <= s_d;
      end
   end

   assign out_s     = s_q;
   assign out_valid = s2_valid_q;

`ifdef LU_ZERO_FLAG_EN
   logic zero_q, zero_d;

   always_comb begin
      zero_d = zero_q;
      if (s2_adv && s1_valid_q) begin
         zero_d = (result == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign out_zero = zero_q;
`endif

endmodule
